input_debounce: RTL
===================

Name: input_debounce

Overview:
- Conditions the raw board inputs (10 slide switches, 4 push buttons) before they reach the processor top's i_ph_sw / i_ph_button ports.
- Synchronises every input into the i_clk domain and debounces each one with a per-bit counter state machine.
- Also produces one-cycle press/release event pulses for the buttons.
- Sits directly upstream of the processor top; its level outputs wire straight into the processor's switch/button inputs.

Parameters:
- NUM_SW, 10, number of switch inputs.
- NUM_BTN, 4, number of button inputs.
- SYNC_STAGES, 2, synchroniser flip-flop depth; must be >= 2.
- DEBOUNCE_CYCLES, 500000, cycles a new level must persist before acceptance (10 ms at 50 MHz); must be >= 2.

Ports:
- i_clk  in  1  system clock; all logic is rising-edge.
- i_reset  in  1  synchronous, active-high reset.
- i_sw_raw  in  NUM_SW  raw asynchronous switch levels.
- i_btn_raw  in  NUM_BTN  raw asynchronous button levels, active-high.
- o_ph_sw  out  NUM_SW  conditioned switch levels.
- o_ph_button  out  NUM_BTN  debounced button levels.
- o_btn_press  out  NUM_BTN  one-cycle pulse per bit on a debounced 0->1 transition.
- o_btn_release  out  NUM_BTN  one-cycle pulse per bit on a debounced 1->0 transition.

Behaviour:
- Reset (synchronous, active-high) clears all of the following to 0:
  - synchroniser flops;
  - counters;
  - every output.
  - Every cell's FSM goes to STABLE.
- Synchroniser: a SYNC_STAGES-deep flop chain per bit. sync_in is the last stage.
- Debounce cell FSM, one per bit. Counter width is $clog2(DEBOUNCE_CYCLES).
  - STABLE: out holds its value and cnt is 0.
    - If sync_in != out: go to CHANGING, cnt <= 1.
  - CHANGING, checked in this priority order:
    1. sync_in == out: the change was a glitch. Return to STABLE, cnt <= 0, out unchanged, no pulse.
    2. cnt == DEBOUNCE_CYCLES-1: out <= sync_in, return to STABLE, cnt <= 0, assert the rise or fall pulse for exactly one cycle.
    3. Otherwise: cnt <= cnt+1.
- Latency: for a clean level change, out updates at rising edge number SYNC_STAGES+DEBOUNCE_CYCLES. Edge 1 is the first edge that samples the new raw level.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Bouncing input: any return of sync_in to the old level restarts the whole acceptance window. The output changes at most once per settled transition.
- Pulses are registered. o_btn_press[i] and o_btn_release[i] are mutually exclusive and never assert in the same cycle as reset.
- Independent bits may pulse in the same cycle.
- Reset mid-CHANGING: the cell aborts, no pulse is emitted, and out is 0.
  - If the raw level is 1 after reset, it is re-debounced with full latency and then produces a press pulse.
- No combinational path from any input to any output.

Optional Feature:
- Macro: DEBOUNCE_SW_EN.
- Defined: switches use full debounce cells. o_ph_sw latency is SYNC_STAGES+DEBOUNCE_CYCLES edges.
- Undefined:
  - Switches are only synchronised: o_ph_sw = sync_in, with latency SYNC_STAGES edges.
  - No switch counters are instantiated.
- Buttons are unaffected in both cases.

Decomposition:
- Package input_debounce_pkg holds:
  - typedef enum logic {DB_STABLE, DB_CHANGING} db_state_e;
  - default constants DB_SYNC_STAGES_DEF and DB_CYCLES_DEF.
- Sub-module debounce_cell (one bit):
  - contains the synchroniser, FSM, counter, rise pulse and fall pulse;
  - takes parameters SYNC_STAGES and DEBOUNCE_CYCLES;
  - the top level instantiates it in generate loops over buttons and, when DEBOUNCE_SW_EN is defined, switches.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, DEBOUNCE_SW_EN defined unless stated):
1. Reset with raw high: hold i_reset with i_btn_raw=4'b1111, then release.
   - All outputs stay 0 during reset.
   - o_ph_button=4'b1111 at edge 6 after release.
   - o_btn_press=4'b1111 for exactly one cycle.
2. Glitch rejection: i_btn_raw[0] high for 3 cycles, then low.
   - o_ph_button stays 4'b0000; no pulses.
3. Clean press and release of button 2:
   - i_btn_raw[2] held high: o_ph_button=4'b0100 at edge 6; o_btn_press=4'b0100 for one cycle.
   - Then held low: o_btn_release=4'b0100 for one cycle, 6 edges later.
4. Bouncing press: i_btn_raw[1] toggles every cycle for 10 cycles, then holds 1.
   - Exactly one press pulse, occurring 6 edges after the final rising raw edge.
5. Switch latency: i_sw_raw=10'h2AA.
   - With DEBOUNCE_SW_EN defined: o_ph_sw=10'h2AA at edge 6.
   - With the macro undefined: o_ph_sw=10'h2AA at edge 2.
6. Reset mid-window: assert i_reset while button 3 is in CHANGING with cnt=2.
   - Outputs are 0 next cycle.
   - No pulse is emitted during the reset cycle.

Source files
------------

// File: rtl/input_debounce_pkg.sv
// Shared types and default constants for the input_debounce block.
// Imported by debounce_cell and input_debounce.
package input_debounce_pkg;

    typedef enum logic {
        DB_STABLE,
        DB_CHANGING
    } db_state_e;

    // 2 flops for metastability, 500000 cycles = 10 ms at 50 MHz
    localparam int DB_SYNC_STAGES_DEF = 2;
    localparam int DB_CYCLES_DEF      = 500000;

endpackage

// File: rtl/debounce_cell.sv
// One-bit input conditioner: synchroniser chain, debounce FSM with acceptance
// counter, and registered rise/fall event pulses.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// DB_STABLE   | o_level settled; counter held at 0
// DB_CHANGING | sync_in differs from o_level; counting toward acceptance
module debounce_cell
    import input_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DB_SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DB_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_in;

    db_state_e              r_state;
    db_state_e              w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_level;
    logic                   w_level_nxt;
    logic                   r_rise;
    logic                   w_rise_nxt;
    logic                   r_fall;
    logic                   w_fall_nxt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_sync_in = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= DB_STABLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // A return to the old level has priority over acceptance, so the
    // window restarts even on the last counted cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            DB_STABLE: begin
                w_cnt_nxt = '0;
                if (w_sync_in != r_level) begin
                    w_state_nxt = DB_CHANGING;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            DB_CHANGING: begin
                if (w_sync_in == r_level) begin
                    w_state_nxt = DB_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DB_STABLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = w_sync_in;
                    w_rise_nxt  = w_sync_in;
                    w_fall_nxt  = ~w_sync_in;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = DB_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/input_debounce.sv
// Board input conditioner feeding the processor's switch/button ports.
// Define DEBOUNCE_SW_EN to debounce switches too; otherwise they are only synchronised.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int NUM_SW          = 10,
    parameter int NUM_BTN         = 4,
    parameter int SYNC_STAGES     = DB_SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DB_CYCLES_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_SW-1:0]  i_sw_raw,
    input  logic [NUM_BTN-1:0] i_btn_raw,
    output logic [NUM_SW-1:0]  o_ph_sw,
    output logic [NUM_BTN-1:0] o_ph_button,
    output logic [NUM_BTN-1:0] o_btn_press,
    output logic [NUM_BTN-1:0] o_btn_release
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        debounce_cell #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cell (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_raw   (i_btn_raw[g]),
            .o_level (o_ph_button[g]),
            .o_rise  (o_btn_press[g]),
            .o_fall  (o_btn_release[g])
        );
    end

`ifdef DEBOUNCE_SW_EN
    // Switch edge events have no consumer; only the levels leave the block.
    logic [NUM_SW-1:0] w_sw_rise;
    logic [NUM_SW-1:0] w_sw_fall;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        debounce_cell #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cell (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_raw   (i_sw_raw[g]),
            .o_level (o_ph_sw[g]),
            .o_rise  (w_sw_rise[g]),
            .o_fall  (w_sw_fall[g])
        );
    end
`else
    logic [SYNC_STAGES-1:0][NUM_SW-1:0] r_sw_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sw_sync <= '0;
        end else begin
            r_sw_sync <= {r_sw_sync[SYNC_STAGES-2:0], i_sw_raw};
        end
    end

    assign o_ph_sw = r_sw_sync[SYNC_STAGES-1];
`endif

endmodule
